// File: rtl/slow_memory_arb.sv
// Shared slow-memory model: NCH requester channels, round-robin arbitration and a fixed
// grant-to-ready latency. The backing array `mem` is not reset and may be loaded hierarchically.
module slow_memory_arb #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned LINE_W  = 128,
    parameter int unsigned ADDR_W  = 28,
    parameter int unsigned MEM_AW  = 12,
    parameter int unsigned LATENCY = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        mem_read,
    input  logic [NCH-1:0]        mem_write,
    input  logic [NCH*ADDR_W-1:0] mem_addr,
    input  logic [NCH*LINE_W-1:0] mem_wdata,
    output logic [NCH*LINE_W-1:0] mem_rdata,
    output logic [NCH-1:0]        mem_ready,
    output logic                  busy,
    output logic [2:0]            grant_id
);

    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned LW = $clog2(LATENCY);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       ch_q, ch_d, last_q, last_d;
    logic                wr_q, wr_d;
    logic [MEM_AW-1:0]   idx_q, idx_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic [LW-1:0]       cnt_q, cnt_d;
    logic [NCH-1:0]      ready_q, ready_d;
    logic [NCH*LINE_W-1:0] rdata_q, rdata_d;
    logic [2:0]          gid_q, gid_d;

    logic [NCH-1:0]      req;
    logic                pick_found;
    logic [CW-1:0]       pick, cand;

    logic [LINE_W-1:0]   mem [0:2**MEM_AW-1];

    // Upper line-address bits are intentionally ignored so addresses wrap.
    logic unused_addr;
    assign unused_addr = ^mem_addr;

    assign req = mem_read | mem_write;

    // Round-robin search starting just after the last served channel.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int unsigned off = 1; off <= NCH; off++) begin
            cand = CW'((int'(last_q) + off) % NCH);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        last_d  = last_q;
        wr_d    = wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        ready_d = '0;
        rdata_d = rdata_q;
        gid_d   = gid_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    ch_d    = pick;
                    gid_d   = 3'(pick);
                    wr_d    = mem_write[pick];
                    idx_d   = mem_addr[int'(pick)*ADDR_W +: MEM_AW];
                    wdata_d = mem_wdata[int'(pick)*LINE_W +: LINE_W];
                    cnt_d   = LW'(LATENCY - 1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q - LW'(1);
                if (cnt_q == LW'(1)) state_d = StDone;
            end
            StDone: begin
                ready_d[ch_q] = 1'b1;
                if (!wr_q) rdata_d[int'(ch_q)*LINE_W +: LINE_W] = mem[idx_q];
                last_d  = ch_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ch_q    <= '0;
            last_q  <= CW'(NCH - 1);
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            ready_q <= '0;
            rdata_q <= '0;
            gid_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            gid_q   <= gid_d;
        end
    end

    // State is forced to idle by reset, so an aborted write never reaches the array.
    always_ff @(posedge clk) begin
        if (state_q == StDone && wr_q) mem[idx_q] <= wdata_q;
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign grant_id  = gid_q;
    assign busy      = (state_q != StIdle) || (|ready_q);

endmodule

// File: tb/tb_slow_memory_arb.sv
// Scoreboard bench for slow_memory_arb: expectations are queued when a request is driven
// and popped when the matching mem_ready pulse appears.
module tb_slow_memory_arb;

    localparam int NCH = 3;
    localparam int LW  = 128;
    localparam int AW  = 28;
    localparam int MAW = 4;
    localparam int LAT = 4;

    typedef struct {
        int           ch;
        bit           rd;
        logic [LW-1:0] data;
        int           cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NCH-1:0]    mem_read, mem_write;
    logic [NCH*AW-1:0] mem_addr;
    logic [NCH*LW-1:0] mem_wdata;
    logic [NCH*LW-1:0] mem_rdata;
    logic [NCH-1:0]    mem_ready;
    logic              busy;
    logic [2:0]        grant_id;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [LW-1:0] ref_mem [16];
    logic [LW-1:0] exp_rd [NCH];

    slow_memory_arb #(
        .NCH(NCH), .LINE_W(LW), .ADDR_W(AW), .MEM_AW(MAW), .LATENCY(LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: every completion pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) exp_rd[c] = '0;
        end else if (|mem_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_ready", LW'(mem_ready), '0);
            end else begin
                mon_e = sb.pop_front();
                check("ready_vec", LW'(mem_ready), LW'(1) << mon_e.ch);
                check("ready_cycle", LW'(cyc), LW'(mon_e.cyc));
                check("grant_id", LW'(grant_id), LW'(mon_e.ch));
                if (mon_e.rd) exp_rd[mon_e.ch] = mon_e.data;
                for (int c = 0; c < NCH; c++) check("rdata", mem_rdata[c*LW +: LW], exp_rd[c]);
            end
        end
    end

    task automatic issue(input int ch, input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [LW-1:0] data);
        exp_t x;
        int   idx;
        bit   got;
        @(negedge clk);
        mem_read[ch]            = rd;
        mem_write[ch]           = wr;
        mem_addr[ch*AW +: AW]   = addr;
        mem_wdata[ch*LW +: LW]  = data;
        idx    = int'(addr[MAW-1:0]);
        x.ch   = ch;
        x.rd   = !wr;
        x.data = ref_mem[idx];
        x.cyc  = cyc + 1 + LAT;
        if (wr) ref_mem[idx] = data;
        sb.push_back(x);
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = mem_ready[ch];
        end
        check("completion_seen", LW'(got), LW'(1));
        mem_read[ch]  = 1'b0;
        mem_write[ch] = 1'b0;
    endtask

    task automatic preload(input int idx, input logic [LW-1:0] v);
        dut.mem[idx] = v;
        ref_mem[idx] = v;
    endtask

    initial begin
        exp_t x;
        int   base, seen;
        rst_n     = 1'b0;
        mem_read  = '0;
        mem_write = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < 16; i++) preload(i, '0);
        #1;
        check("rst_ready", LW'(mem_ready), '0);
        check("rst_busy", LW'(busy), '0);
        check("rst_grant_id", LW'(grant_id), '0);
        for (int c = 0; c < NCH; c++) check("rst_rdata", mem_rdata[c*LW +: LW], '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single read with exact latency and busy window.
        preload(5, {16{8'hA5}});
        @(negedge clk);
        mem_read[0]       = 1'b1;
        mem_addr[0 +: AW] = AW'(5);
        check("busy_before", LW'(busy), '0);
        x.ch = 0; x.rd = 1'b1; x.data = {16{8'hA5}}; x.cyc = cyc + 1 + LAT;
        sb.push_back(x);
        for (int i = 0; i <= LAT + 1; i++) begin
            @(negedge clk);
            check("busy_window", LW'(busy), LW'(i <= LAT));
            if (i == 0) check("grant_first", LW'(grant_id), '0);
            if (i == LAT) mem_read[0] = 1'b0;
        end

        // Write then read on channel 1; channel 0 rdata must hold.
        issue(1, 1'b0, 1'b1, AW'(3), LW'(128'h1234));
        issue(1, 1'b1, 1'b0, AW'(3), '0);

        // Address wrap at MEM_AW=4.
        issue(2, 1'b0, 1'b1, AW'(28'h13), LW'(128'hBEEF));
        issue(0, 1'b1, 1'b0, AW'(28'h3), '0);

        // Read and write together: acts as a write.
        issue(1, 1'b1, 1'b1, AW'(9), LW'(128'hCAFE));
        issue(2, 1'b1, 1'b0, AW'(9), '0);

        // Contention: all channels request out of reset, service 0,1,2,0,1,2.
        preload(10, LW'(128'h1010));
        preload(11, LW'(128'h1111));
        preload(12, LW'(128'h1212));
        @(negedge clk);
        rst_n = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            mem_read[c]           = 1'b1;
            mem_addr[c*AW +: AW]  = AW'(10 + c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        base = cyc + 1 + LAT;
        for (int j = 0; j < 2 * NCH; j++) begin
            x.ch = j % NCH; x.rd = 1'b1; x.data = ref_mem[10 + (j % NCH)];
            x.cyc = base + j * (LAT + 1);
            sb.push_back(x);
        end
        seen = 0;
        for (int i = 0; i < 100 && seen < 2 * NCH; i++) begin
            @(negedge clk);
            if (|mem_ready) seen++;
        end
        check("contention_count", LW'(seen), LW'(2 * NCH));
        mem_read = '0;

        // Reset two cycles into a write aborts it.
        repeat (2) @(negedge clk);
        mem_write[0]       = 1'b1;
        mem_addr[0 +: AW]  = AW'(7);
        mem_wdata[0 +: LW] = LW'(128'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ready", LW'(mem_ready), '0);
        check("abort_busy", LW'(busy), '0);
        check("abort_grant_id", LW'(grant_id), '0);
        for (int c = 0; c < NCH; c++) check("abort_rdata", mem_rdata[c*LW +: LW], '0);
        mem_write = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        issue(0, 1'b1, 1'b0, AW'(7), '0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", LW'(sb.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
